// File: rtl/score_display_pkg.sv
// -----------------------------------------------------------------------------
// score_display_pkg
// Shared constants and types for the score/time digit scanner.
//   BLANK_CODE  : digit code the downstream 7-seg decoder renders as all-off
//   NUM_DIGITS  : number of scanned display positions
//   SCORE_D0..4 : display slots for score ones..ten-thousands
//   BLANK_SLOT  : unused slot between score and timer, always blank
//   TIME_ONES/TENS : display slots for the timer
//   conv_state_e: conversion FSM states
//   sat_time()  : clamps the timer input to the two-digit range
// -----------------------------------------------------------------------------
package score_display_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         NUM_DIGITS = 8;

  localparam int SCORE_D0   = 0;
  localparam int SCORE_D1   = 1;
  localparam int SCORE_D2   = 2;
  localparam int SCORE_D3   = 3;
  localparam int SCORE_D4   = 4;
  localparam int BLANK_SLOT = 5;
  localparam int TIME_ONES  = 6;
  localparam int TIME_TENS  = 7;

  localparam logic [6:0] TIME_MAX = 7'd99;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_e;

  // Timer shows two digits only, so anything above 99 pins at 99.
  function automatic logic [6:0] sat_time(input logic [6:0] t);
    return (t > TIME_MAX) ? TIME_MAX : t;
  endfunction

endpackage

// File: rtl/bcd_serial_converter.sv
// -----------------------------------------------------------------------------
// bcd_serial_converter
// Serial double-dabble binary-to-BCD converter, one step per clock.
//   clock   in   system clock
//   reset   in   synchronous active-high reset
//   start   in   load bin_in and begin a WIDTH-step conversion
//   bin_in  in   binary value, sampled when start is high
//   busy    out  high while steps remain
//   bcd_out out  DIGITS packed BCD nibbles (ones in the low nibble);
//                valid once busy is low and held until the next start
// -----------------------------------------------------------------------------
module bcd_serial_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int SR_W  = WIDTH + 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Layout: [BCD nibbles | binary bits still to be shifted in]
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [SR_W-1:0]  sr_adj;
  logic [3:0]       nib_adj [DIGITS];

  // Add-3 correction on every BCD nibble that would overflow after doubling.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib_adj[gi] = (sr_q[WIDTH+4*gi +: 4] >= 4'd5) ?
                         sr_q[WIDTH+4*gi +: 4] + 4'd3 :
                         sr_q[WIDTH+4*gi +: 4];
  end

  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      sr_adj[WIDTH+4*i +: 4] = nib_adj[i];
    end
  end

  always_comb begin
    sr_d    = sr_q;
    steps_d = steps_q;
    if (start) begin
      sr_d    = SR_W'(bin_in);
      steps_d = CNT_W'(WIDTH);
    end else if (steps_q != '0) begin
      sr_d    = sr_adj << 1;
      steps_d = steps_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q    <= '0;
      steps_q <= '0;
    end else begin
      sr_q    <= sr_d;
      steps_q <= steps_d;
    end
  end

  assign busy    = (steps_q != '0);
  assign bcd_out = sr_q[SR_W-1 -: 4*DIGITS];

endmodule

// File: rtl/score_digit_scanner.sv
// -----------------------------------------------------------------------------
// score_digit_scanner
// Converts the binary score and seconds-left to BCD in a free-running
// LOAD -> SHIFT -> COMMIT loop, latches the blanked digits, and scans the 8
// display slots round-robin for the downstream seven-segment decoder.
//   clock          in   system clock
//   reset          in   synchronous active-high reset
//   score          in   binary score, sampled in LOAD
//   time_left      in   binary seconds left, sampled in LOAD, clamped to 99
//   display_en     in   0 blanks every slot from the next scan tick
//   digit_data     out  BCD digit for the active slot, 4'hF when blank
//   display_select out  active slot 0..7
//   update_pulse   out  high during the COMMIT cycle only
// -----------------------------------------------------------------------------
module score_digit_scanner
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int SCORE_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic [6:0]         time_left,
  input  logic               display_en,
  output logic [3:0]         digit_data,
  output logic [2:0]         display_select,
  output logic               update_pulse
);

  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int SHIFT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  conv_state_e        state_q;
  logic [SHIFT_W-1:0] shift_cnt_q;
  logic               update_pulse_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= LOAD;
      shift_cnt_q    <= '0;
      update_pulse_q <= 1'b0;
    end else begin
      update_pulse_q <= 1'b0;
      case (state_q)
        LOAD: begin
          state_q     <= SHIFT;
          shift_cnt_q <= '0;
        end
        SHIFT: begin
          if (shift_cnt_q == SHIFT_W'(SCORE_W - 1)) begin
            state_q        <= COMMIT;
            update_pulse_q <= 1'b1;
          end else begin
            shift_cnt_q <= shift_cnt_q + SHIFT_W'(1);
          end
        end
        COMMIT:  state_q <= LOAD;
        default: state_q <= LOAD;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Converters: both start together; the timer finishes early and holds.
  // ---------------------------------------------------------------------------
  logic                 conv_start;
  logic [19:0]          score_bcd;
  logic [7:0]           time_bcd;
  logic                 score_busy, time_busy;
  logic                 unused_busy;

  assign conv_start  = (state_q == LOAD);
  assign unused_busy = score_busy ^ time_busy;

  bcd_serial_converter #(
    .WIDTH  (SCORE_W),
    .DIGITS (5)
  ) u_score_conv (
    .clock   (clock),
    .reset   (reset),
    .start   (conv_start),
    .bin_in  (score),
    .busy    (score_busy),
    .bcd_out (score_bcd)
  );

  bcd_serial_converter #(
    .WIDTH  (7),
    .DIGITS (2)
  ) u_time_conv (
    .clock   (clock),
    .reset   (reset),
    .start   (conv_start),
    .bin_in  (sat_time(time_left)),
    .busy    (time_busy),
    .bcd_out (time_bcd)
  );

  // ---------------------------------------------------------------------------
  // Display registers, written only in COMMIT so no partial result is visible.
  // Blanking is resolved here so the scanner just copies register contents.
  // ---------------------------------------------------------------------------
  logic [3:0] disp_q [NUM_DIGITS];
  logic [3:0] disp_d [NUM_DIGITS];
  logic       lead_zero;

  always_comb begin
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      disp_d[i] = disp_q[i];
    end
    if (state_q == COMMIT) begin
      // Walk from the most significant score digit down; stop blanking at
      // the first non-zero so interior zeros are shown.
      for (int i = SCORE_D4; i >= SCORE_D1; i--) begin
        if (lead_zero && (score_bcd[4*i +: 4] == 4'd0)) begin
          disp_d[i] = BLANK_CODE;
        end else begin
          disp_d[i] = score_bcd[4*i +: 4];
          lead_zero = 1'b0;
        end
      end
      disp_d[SCORE_D0]   = score_bcd[3:0];
      disp_d[BLANK_SLOT] = BLANK_CODE;
      disp_d[TIME_ONES]  = time_bcd[3:0];
      disp_d[TIME_TENS]  = (time_bcd[7:4] == 4'd0) ? BLANK_CODE : time_bcd[7:4];
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_disp
    always_ff @(posedge clock) begin
      if (reset) begin
        disp_q[gi] <= BLANK_CODE;
      end else begin
        disp_q[gi] <= disp_d[gi];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh scanner. Reads disp_d so a COMMIT on the same edge as a scan
  // tick is seen immediately.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] refresh_cnt_q;
  logic [2:0]       select_q;
  logic [2:0]       select_next;
  logic [3:0]       digit_q;
  logic             scan_tick;

  assign scan_tick   = (refresh_cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign select_next = select_q + 3'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt_q <= '0;
      select_q      <= 3'd0;
      digit_q       <= BLANK_CODE;
    end else begin
      refresh_cnt_q <= scan_tick ? '0 : refresh_cnt_q + CNT_W'(1);
      if (scan_tick) begin
        select_q <= select_next;
        digit_q  <= display_en ? disp_d[select_next] : BLANK_CODE;
      end
    end
  end

  assign digit_data     = digit_q;
  assign display_select = select_q;
  assign update_pulse   = update_pulse_q;

endmodule

// File: tb/tb_score_digit_scanner.sv
module tb_score_digit_scanner;

  localparam int RDIV   = 4;
  localparam int PERIOD = 18;

  logic        clk;
  logic        reset;
  logic [15:0] score;
  logic [6:0]  time_left;
  logic        display_en;
  logic [3:0]  digit_data;
  logic [2:0]  display_select;
  logic        update_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [3:0]  m_disp [8];
  int          m_cnt;
  int          m_sel;
  int          m_phase;
  logic [3:0]  m_digit;
  logic [31:0] sb_q [$];
  logic [3:0]  cap [8];

  score_digit_scanner #(
    .REFRESH_DIV (RDIV),
    .SCORE_W     (16)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .score          (score),
    .time_left      (time_left),
    .display_en     (display_en),
    .digit_data     (digit_data),
    .display_select (display_select),
    .update_pulse   (update_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected display contents computed arithmetically, packed {d7..d0}.
  function automatic logic [31:0] exp_digits(input logic [15:0] s, input logic [6:0] t);
    int         sv, tv;
    logic [3:0] d [8];
    bit         lead;
    logic [31:0] v;
    sv = int'(s);
    tv = (t > 7'd99) ? 99 : int'(t);
    d[0] = 4'(sv % 10);
    d[1] = 4'((sv / 10) % 10);
    d[2] = 4'((sv / 100) % 10);
    d[3] = 4'((sv / 1000) % 10);
    d[4] = 4'((sv / 10000) % 10);
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && d[i] == 4'd0) d[i] = 4'hF;
      else lead = 1'b0;
    end
    d[5] = 4'hF;
    d[6] = 4'(tv % 10);
    d[7] = 4'(tv / 10);
    if (d[7] == 4'd0) d[7] = 4'hF;
    v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = d[i];
    return v;
  endfunction

  function automatic logic [31:0] cap_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = cap[i];
    return v;
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_sel   = 0;
    m_phase = 0;
    m_digit = 4'hF;
    for (int i = 0; i < 8; i++) m_disp[i] = 4'hF;
    sb_q.delete();
  endtask

  // One clock: push what LOAD will sample, advance the model, compare.
  task automatic cycle();
    logic        en_edge;
    logic [31:0] e;
    if (m_phase == 0) sb_q.push_back(exp_digits(score, time_left));
    en_edge = display_en;
    @(posedge clk);
    #1;
    if (m_phase == PERIOD - 1) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < 8; i++) m_disp[i] = e[4*i +: 4];
      end
    end
    if (m_cnt == RDIV - 1) begin
      m_cnt   = 0;
      m_sel   = (m_sel + 1) % 8;
      m_digit = en_edge ? m_disp[m_sel] : 4'hF;
    end else begin
      m_cnt++;
    end
    m_phase = (m_phase == PERIOD - 1) ? 0 : m_phase + 1;
    check_eq("select", 32'(display_select), 32'(m_sel));
    check_eq("digit", 32'(digit_data), 32'(m_digit));
    check_eq("pulse", 32'(update_pulse), 32'(m_phase == PERIOD - 1));
    cap[display_select] = digit_data;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < 2 * PERIOD && m_phase != ph; i++) cycle();
    check_eq("reach_phase", 32'(m_phase), 32'(ph));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_reset();
      check_eq("rst_select", 32'(display_select), 32'd0);
      check_eq("rst_digit", 32'(digit_data), 32'hF);
      check_eq("rst_pulse", 32'(update_pulse), 32'd0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    score      = 16'd0;
    time_left  = 7'd0;
    display_en = 1'b1;
    for (int i = 0; i < 8; i++) cap[i] = 4'h0;
    model_reset();

    do_reset(3);
    run(60);
    check_eq("scan_zero", cap_vec(), 32'hF0FF_FFF0);
    $display("txn score=0 time=0 scan=%h", cap_vec());

    score = 16'd65535; time_left = 7'd59;
    run(76);
    check_eq("scan_65535", cap_vec(), 32'h59F6_5535);
    $display("txn score=65535 time=59 scan=%h", cap_vec());

    score = 16'd1204; time_left = 7'd120;
    run(76);
    check_eq("scan_1204_sat", cap_vec(), 32'h99FF_1204);
    $display("txn score=1204 time=120 scan=%h", cap_vec());

    score = 16'd100; time_left = 7'd0;
    run(76);
    check_eq("scan_100", cap_vec(), 32'hF0FF_F100);
    $display("txn score=100 time=0 scan=%h", cap_vec());
    run_to_phase(1);
    run_to_phase(5);
    score = 16'd200;
    run(76);
    check_eq("scan_200", cap_vec(), 32'hF0FF_F200);
    $display("txn score=200 changed mid-shift scan=%h", cap_vec());

    display_en = 1'b0;
    run(40);
    check_eq("scan_disabled", cap_vec(), 32'hFFFF_FFFF);
    $display("txn display_en=0 scan=%h", cap_vec());
    display_en = 1'b1;
    run(40);
    check_eq("scan_reenabled", cap_vec(), 32'hF0FF_F200);
    $display("txn display_en=1 scan=%h", cap_vec());

    score = 16'd4321; time_left = 7'd7;
    run_to_phase(6);
    do_reset(1);
    run(60);
    check_eq("scan_after_rst", cap_vec(), 32'hF7FF_4321);
    $display("txn mid-shift reset score=4321 time=7 scan=%h", cap_vec());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_digit_scanner.md
Name: score_digit_scanner

Overview:
- Upstream feeder for the 8-digit seven-segment decoder; drives that decoder's digit_data/display_select inputs.
- Continuously converts the binary game score and time-left to BCD using serial double-dabble, then scans the 8 digits round-robin at a divided refresh rate.
- Applies leading-zero blanking.
- Blank digits are sent as code 4'hF, which the decoder renders with all segments off.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot; range 2..2^20.
- SCORE_W, 16, score input width; 5 BCD digits cover a maximum of 65535.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- score  in  SCORE_W  binary score; sampled at conversion start
- time_left  in  7  binary seconds remaining; sampled at conversion start; values >99 saturate to 99
- display_en  in  1  0 forces every digit to blank (4'hF)
- digit_data  out  4  BCD digit, or 4'hF for blank
- display_select  out  3  active digit index 0..7
- update_pulse  out  1  one-cycle pulse when the displayed values are refreshed

Behaviour:
- Reset values:
  - display_select=0, digit_data=4'hF, update_pulse=0.
  - All 8 display registers = 4'hF.
  - Refresh counter = 0; FSM in LOAD.
- Conversion FSM (LOAD -> SHIFT -> COMMIT -> LOAD, free-running):
  - LOAD, 1 cycle: sample score and sat(time_left); start both converters.
  - SHIFT, SCORE_W cycles: one double-dabble step per cycle (add 3 to any nibble >=5, then shift left 1). The 7-bit timer converter finishes after 7 steps and then holds its result.
  - COMMIT, 1 cycle: write the display registers; update_pulse=1 in this cycle only.
  - Period is SCORE_W+2 = 18 cycles. Latency from score sample to registers updated is 17 cycles.
- Input stability: changes to score/time_left during SHIFT are ignored until the next LOAD. Display registers never show a partial result.
- Digit map:
  - Digits 0..4 = score BCD ones..ten-thousands.
  - Digit 5 = blank.
  - Digit 6 = time ones, digit 7 = time tens.
- Leading-zero blanking:
  - Score: digits 4 down to 1 are blanked while they and every higher score digit are 0. Digit 0 always shows, so score 0 displays "0".
  - Time: tens blanked when 0; ones always shown.
- Refresh scanning:
  - Counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle, display_select <= display_select+1 (7 wraps to 0). In the same edge, digit_data <= display_register[new select], or 4'hF if display_en=0.
  - digit_data and display_select therefore always change on the same edge.
- COMMIT coincident with a scan tick: the digit output samples the newly committed value (write-first).
- display_en: takes effect at the next scan tick. Conversion keeps running while display_en=0.
- Mid-operation reset: takes effect at the next edge. Conversion is aborted and restarts from LOAD. Outputs return to reset values.
- Arithmetic:
  - Score shift register is SCORE_W+20 bits wide.
  - Timer shift register is 7+8 bits wide.
  - No overflow is possible for in-range inputs.

Decomposition:
- Package score_display_pkg:
  - BLANK_CODE = 4'hF.
  - NUM_DIGITS = 8.
  - Digit index constants (SCORE_D0..D4, TIME_ONES, TIME_TENS).
  - FSM state enum {LOAD, SHIFT, COMMIT}.
- Sub-module bcd_serial_converter, instantiated twice:
  - Score instance: WIDTH=SCORE_W, DIGITS=5.
  - Timer instance: WIDTH=7, DIGITS=2.
  - Ports: clock, reset, start, bin_in, busy, bcd_out.

Test Plan (REFRESH_DIV=4):
- Reset, then score=0 and time_left=0: after one COMMIT plus a full scan, digits 0..7 = 0,F,F,F,F,F,0,F; update_pulse fires every 18 cycles.
- score=65535, time_left=59: scan yields 5,3,5,5,6,F,9,5 on selects 0..7; display_select advances every 4 cycles and wraps from 7 to 0.
- score=1204, time_left=120 (saturate): digits 4,0,2,1,F,F,9,9. The interior zero is shown; only the leading zero is blanked.
- Change score from 100 to 200 during SHIFT: the display shows 0,0,1 until COMMIT, 200 only after the following full cycle, and never a mixed value.
- display_en=0 then 1: digit_data=F from the next scan tick onward, and the real digits return at the first scan tick after re-enable; update_pulse cadence is unaffected.
- Assert reset for 1 cycle mid-SHIFT: next cycle shows display_select=0, digit_data=F, all registers blank; the first new update_pulse arrives 17 cycles after reset is released.
